// File: rtl/lock_key_pkg.sv
// Shared types, constants and checksum helper for the serial key loader.
package lock_key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_KEY = 2'd1,
    SHIFT_CHK = 2'd2,
    CHECK     = 2'd3
  } key_ld_state_t;

  localparam int unsigned LK_CHK_W     = 8;
  // Widest key the fold helper accepts; narrower keys are zero-extended.
  localparam int unsigned LK_KEY_MAX_W = 256;

  // Byte-wise XOR of the key; zero padding does not change the result.
  function automatic logic [LK_CHK_W-1:0] lk_xor_fold(input logic [LK_KEY_MAX_W-1:0] key);
    logic [LK_CHK_W-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < LK_KEY_MAX_W / LK_CHK_W; b++) begin
      acc = acc ^ key[b*LK_CHK_W +: LK_CHK_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/lock_key_loader_if.sv
// Key-store serial link plus committed-key bus toward the locked adder.
interface lock_key_loader_if #(
  parameter int unsigned KEY_W = 32
);
  logic             key_start;
  logic             key_sen;
  logic             key_sdi;
  logic [KEY_W-1:0] keyinput;
  logic             key_valid;
  logic             key_err;
  logic             busy;

  modport master (
    output key_start, key_sen, key_sdi,
    input  keyinput, key_valid, key_err, busy
  );

  modport slave (
    input  key_start, key_sen, key_sdi,
    output keyinput, key_valid, key_err, busy
  );
endinterface

// File: rtl/lk_shift_ctr.sv
// Bit counter shared by both shift phases; flags the phase's last bit.
module lk_shift_ctr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tc_c = (r_cnt == i_last);

endmodule

// File: rtl/lock_key_loader.sv
// Receives the unlock key serially, verifies its XOR checksum and only then
// commits it to the locked adder's keyinput bus.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned CHK_W = LK_CHK_W
) (
  input logic               clk,
  input logic               rst_n,
  lock_key_loader_if.slave  bus
);

  localparam int unsigned CNT_W     = $clog2(KEY_W);
  localparam int unsigned CHK_IDX_W = $clog2(CHK_W);

  key_ld_state_t    r_state;
  logic [KEY_W-1:0] r_shadow;
  logic [CHK_W-1:0] r_chk;
  logic [KEY_W-1:0] r_keyinput;
  logic             r_key_valid;
  logic             r_key_err;
  logic             r_busy;

  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W-1:0]    w_last;
  logic                w_tc;
  logic                w_take;
  logic                w_ctr_clr;
  logic [LK_CHK_W-1:0] w_fold;
  logic                w_chk_ok;

  // A bit is consumed only while shifting and the key store asserts key_sen.
  assign w_take    = bus.key_sen & ((r_state == SHIFT_KEY) | (r_state == SHIFT_CHK));
  assign w_last    = (r_state == SHIFT_CHK) ? CNT_W'(CHK_W - 1) : CNT_W'(KEY_W - 1);
  assign w_ctr_clr = ((r_state == IDLE) & bus.key_start) | (w_take & w_tc);
  assign w_fold    = lk_xor_fold(LK_KEY_MAX_W'(r_shadow));
  assign w_chk_ok  = (CHK_W'(w_fold) == r_chk);

  lk_shift_ctr #(.W(CNT_W)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_ctr_clr),
    .i_inc  (w_take),
    .i_last (w_last),
    .o_cnt  (w_cnt),
    .o_tc_c (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_chk       <= '0;
      r_keyinput  <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.key_start) begin
            r_state     <= SHIFT_KEY;
            r_shadow    <= '0;
            r_chk       <= '0;
            r_keyinput  <= '0;
            r_key_valid <= 1'b0;
            r_key_err   <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        SHIFT_KEY: begin
          if (w_take) begin
            r_shadow[w_cnt] <= bus.key_sdi;
            if (w_tc) r_state <= SHIFT_CHK;
          end
        end
        SHIFT_CHK: begin
          if (w_take) begin
            r_chk[w_cnt[CHK_IDX_W-1:0]] <= bus.key_sdi;
            if (w_tc) r_state <= CHECK;
          end
        end
        CHECK: begin
          // Shadow reaches keyinput only through this verified commit.
          if (w_chk_ok) begin
            r_keyinput  <= r_shadow;
            r_key_valid <= 1'b1;
            r_key_err   <= 1'b0;
          end else begin
            r_keyinput  <= '0;
            r_key_valid <= 1'b0;
            r_key_err   <= 1'b1;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.keyinput  = r_keyinput;
  assign bus.key_valid = r_key_valid;
  assign bus.key_err   = r_key_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_lock_key_loader.sv
// Randomized bench for lock_key_loader against a bit-queue reference model.
module tb_lock_key_loader;

  localparam int unsigned KW = 32;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lock_key_loader_if #(.KEY_W(KW)) bus();

  lock_key_loader #(.KEY_W(KW), .CHK_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h (cycle %0d)", tag, name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string tag, input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %b expected %b (cycle %0d)", tag, name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fold_ref(input logic [31:0] k);
    logic [7:0] f;
    f = 8'h00;
    for (int b = 0; b < 4; b++) f = f ^ 8'((k >> (8 * b)) & 32'hFF);
    return f;
  endfunction

  // Reference model: collect accepted bits, judge the load once all 40 are in.
  bit          m_busy;
  logic [31:0] m_key;
  bit          m_valid;
  bit          m_err;
  bit          m_q[$];
  logic [31:0] m_k;
  logic [7:0]  m_c;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_key = '0; m_valid = 1'b0; m_err = 1'b0;
      m_q.delete();
    end else if (!m_busy) begin
      if (bus.key_start) begin
        m_busy = 1'b1; m_key = '0; m_valid = 1'b0; m_err = 1'b0;
        m_q.delete();
      end
    end else if (m_q.size() == KW + CW) begin
      for (int i = 0; i < 32; i++) m_k[i] = m_q[i];
      for (int i = 0; i < 8; i++)  m_c[i] = m_q[32 + i];
      if (fold_ref(m_k) == m_c) begin
        m_key = m_k; m_valid = 1'b1; m_err = 1'b0;
      end else begin
        m_key = '0; m_valid = 1'b0; m_err = 1'b1;
      end
      m_busy = 1'b0;
    end else if (bus.key_sen) begin
      m_q.push_back(bus.key_sdi);
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check1("model", "busy", bus.busy, m_busy);
      check1("model", "key_valid", bus.key_valid, m_valid);
      check1("model", "key_err", bus.key_err, m_err);
      check32("model", "keyinput", bus.keyinput, m_key);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // One full load: optional stalls at random bit positions and an optional
  // extra key_start pulse sampled restart_at edges after the accepted one.
  task automatic run_load(input logic [31:0] key, input logic [7:0] ck, input int nstall,
                          input int restart_at, input bit exp_ok, input string tag);
    int          pos[$];
    int          t0;
    int          ns;
    logic [39:0] bits;
    bits = {ck, key};
    for (int s = 0; s < nstall; s++) pos.push_back(int'($urandom_range(1, 39)));
    @(negedge clk);
    bus.key_start = 1'b1;
    bus.key_sen   = 1'($urandom);
    bus.key_sdi   = 1'($urandom);
    @(negedge clk);
    t0 = cyc;
    check1(tag, "busy_after_start", bus.busy, 1'b1);
    check1(tag, "valid_cleared", bus.key_valid, 1'b0);
    check1(tag, "err_cleared", bus.key_err, 1'b0);
    check32(tag, "keyinput_cleared", bus.keyinput, 32'h0);
    for (int j = 0; j < 40; j++) begin
      ns = 0;
      foreach (pos[p]) if (pos[p] == j) ns++;
      repeat (ns) begin
        bus.key_start = (cyc - t0 + 1 == restart_at);
        bus.key_sen   = 1'b0;
        bus.key_sdi   = 1'($urandom);
        @(negedge clk);
      end
      bus.key_start = (cyc - t0 + 1 == restart_at);
      bus.key_sen   = 1'b1;
      bus.key_sdi   = bits[j];
      @(negedge clk);
    end
    check1(tag, "busy_before_check", bus.busy, 1'b1);
    check1(tag, "valid_before_check", bus.key_valid, 1'b0);
    bus.key_start = 1'b0;
    bus.key_sen   = 1'($urandom);
    bus.key_sdi   = 1'($urandom);
    @(negedge clk);
    check1(tag, "busy_done", bus.busy, 1'b0);
    check1(tag, "key_valid", bus.key_valid, exp_ok);
    check1(tag, "key_err", bus.key_err, !exp_ok);
    check32(tag, "keyinput", bus.keyinput, exp_ok ? key : 32'h0);
    bus.key_sen = 1'b0;
  endtask

  initial begin
    logic [31:0] rk;
    logic [7:0]  rc;
    bit          good;
    bus.key_start = 1'b0;
    bus.key_sen   = 1'b0;
    bus.key_sdi   = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check1("reset", "busy", bus.busy, 1'b0);
    check1("reset", "key_valid", bus.key_valid, 1'b0);
    check1("reset", "key_err", bus.key_err, 1'b0);
    check32("reset", "keyinput", bus.keyinput, 32'h0);
    rst_n = 1'b1;

    // Abort a load after 10 key bits with a reset.
    @(negedge clk);
    bus.key_start = 1'b1;
    @(negedge clk);
    bus.key_start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bus.key_sen = 1'b1;
      bus.key_sdi = 1'($urandom);
      @(negedge clk);
    end
    check1("midreset", "busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.key_sen = 1'b0;
    @(negedge clk);
    check1("midreset", "busy", bus.busy, 1'b0);
    check1("midreset", "key_valid", bus.key_valid, 1'b0);
    check1("midreset", "key_err", bus.key_err, 1'b0);
    check32("midreset", "keyinput", bus.keyinput, 32'h0);

    run_load(32'hA5C3_0F1E, 8'h77, 0, 0, 1'b1, "good");
    run_load(32'hA5C3_0F1E, 8'h76, 0, 0, 1'b0, "badchk");
    run_load(32'hFFFF_FFFF, 8'h00, 5, 0, 1'b1, "stall5");
    run_load(32'hA5C3_0F1E, 8'h77, 0, 20, 1'b1, "restart20");
    run_load(32'hA5C3_0F1E, 8'h00, 0, 0, 1'b0, "bad_after_good");

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.key_sen = 1'($urandom);
        bus.key_sdi = 1'($urandom);
      end
      rk   = $urandom;
      good = 1'($urandom);
      rc   = good ? fold_ref(rk) : (fold_ref(rk) ^ (8'h01 << $urandom_range(0, 7)));
      run_load(rk, rc, int'($urandom_range(0, 6)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 38)) : 0, good, "rand");
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
